// File: rtl/mac_dump_scaler_pkg.sv
//------------------------------------------------------------------------------
// macDumpPkg : widths and pipeline constants shared by the MAC dump stages
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package macDumpPkg;
   localparam int MAC_PIPE_LAT = 3;
   localparam int P_WIDTH      = 48;
   localparam int OP_WIDTH     = 18;

   typedef logic signed [OP_WIDTH-1:0] op_t;
   typedef logic signed [P_WIDTH-1:0]  p_t;
endpackage

`default_nettype wire

// File: rtl/dsp48_mac.sv
//------------------------------------------------------------------------------
// dsp48_mac : signed 18x18 multiply-accumulator, operand reg -> mReg -> p
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsp48_mac
   import macDumpPkg::*;
(
   input  logic clk,
   input  logic reset,
   input  op_t  a,
   input  op_t  b,
   input  logic acc,
   input  logic accClr,
   output p_t   p
);

   op_t                             aReg_q, bReg_q;
   p_t                              mReg_q, pReg_q;
   logic signed [2*OP_WIDTH-1:0]    prod;

   assign prod = aReg_q * bReg_q;
   assign p    = pReg_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aReg_q <= '0;
         bReg_q <= '0;
         mReg_q <= '0;
         pReg_q <= '0;
      end else begin
         aReg_q <= a;
         bReg_q <= b;
         mReg_q <= {{(P_WIDTH-2*OP_WIDTH){prod[2*OP_WIDTH-1]}}, prod};
         if (accClr)
            pReg_q <= '0;
         else if (acc)
            pReg_q <= pReg_q + mReg_q;
         else
            pReg_q <= mReg_q;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_dump_sat.sv
//------------------------------------------------------------------------------
// mac_dump_sat : combinational round / arithmetic shift / saturate of a 48-bit
//                accumulator. MAC_DUMP_ROUND_EN selects round-half-up,
//                otherwise the shift truncates toward negative infinity.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_dump_sat
   import macDumpPkg::*;
#(
   parameter int SHIFT     = 17,
   parameter int OUT_WIDTH = 18
) (
   input  p_t                          pIn,
   output logic signed [OUT_WIDTH-1:0] qOut,
   output logic                        satOut
);

   localparam p_t C_MAX = {{(P_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam p_t C_MIN = {{(P_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef MAC_DUMP_ROUND_EN
   localparam p_t C_HALF = {{(P_WIDTH-1){1'b0}}, 1'b1} << (SHIFT-1);
`else
   localparam p_t C_HALF = '0;
`endif

   p_t rnd, shf;

   always_comb begin
      rnd    = pIn + C_HALF;
      shf    = rnd >>> SHIFT;
      satOut = 1'b0;
      qOut   = shf[OUT_WIDTH-1:0];
      if (shf > C_MAX) begin
         qOut   = C_MAX[OUT_WIDTH-1:0];
         satOut = 1'b1;
      end else if (shf < C_MIN) begin
         qOut   = C_MIN[OUT_WIDTH-1:0];
         satOut = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_dump_scaler.sv
//------------------------------------------------------------------------------
// mac_dump_scaler : operand gating, MAC acc/accClr sequencing and scaled dump
//                   of every SUM_LEN products. Rounding via MAC_DUMP_ROUND_EN.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_dump_scaler
   import macDumpPkg::*;
#(
   parameter int SUM_LEN   = 16,
   parameter int SHIFT     = 17,
   parameter int OUT_WIDTH = 18
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic signed [OP_WIDTH-1:0]  aIn,
   input  logic signed [OP_WIDTH-1:0]  bIn,
   input  logic                        inValid,
   output logic signed [OP_WIDTH-1:0]  macA,
   output logic signed [OP_WIDTH-1:0]  macB,
   output logic                        macAcc,
   output logic                        macAccClr,
   input  logic signed [P_WIDTH-1:0]   macP,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        doutValid,
   output logic                        satFlag
);

   localparam int             CNT_W    = (SUM_LEN > 1) ? $clog2(SUM_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUM_LEN-1);

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [MAC_PIPE_LAT-1:0]     first_q, first_d;
   logic [MAC_PIPE_LAT:0]       last_q, last_d;
   op_t                         macA_q, macA_d, macB_q, macB_d;
   logic                        clr_q, clr_d;
   logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
   logic                        dv_q, dv_d;
   logic                        sat_q, sat_d;
   logic                        accept;
   logic signed [OUT_WIDTH-1:0] scaled;
   logic                        scaledSat;

   mac_dump_sat #(
      .SHIFT     (SHIFT),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat (
      .pIn    (macP),
      .qOut   (scaled),
      .satOut (scaledSat)
   );

   assign accept = inValid & ~flush;

   always_comb begin
      cnt_d   = cnt_q;
      first_d = {first_q[MAC_PIPE_LAT-2:0], accept & (cnt_q == '0)};
      last_d  = {last_q[MAC_PIPE_LAT-1:0], accept & (cnt_q == CNT_LAST)};
      if (accept)
         cnt_d = (cnt_q == CNT_LAST) ? '0 : CNT_W'(cnt_q + 1'b1);
      if (flush) begin
         cnt_d   = '0;
         first_d = '0;
         last_d  = '0;
      end
      macA_d = accept ? aIn : '0;
      macB_d = accept ? bIn : '0;
      clr_d  = flush;
      // last_q MSB marks the cycle in which p holds the completed block sum
      dv_d   = last_q[MAC_PIPE_LAT] & ~flush;
      dout_d = dv_d ? scaled : dout_q;
      sat_d  = flush ? 1'b0 : (sat_q | (dv_d & scaledSat));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
         macA_q  <= '0;
         macB_q  <= '0;
         clr_q   <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         first_q <= first_d;
         last_q  <= last_d;
         macA_q  <= macA_d;
         macB_q  <= macB_d;
         clr_q   <= clr_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         sat_q   <= sat_d;
      end
   end

   assign macA      = macA_q;
   assign macB      = macB_q;
   assign macAcc    = ~first_q[MAC_PIPE_LAT-1] & ~reset;
   assign macAccClr = reset | clr_q;
   assign dout      = dout_q;
   assign doutValid = dv_q;
   assign satFlag   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_dump_scaler.sv
//------------------------------------------------------------------------------
// tb_mac_dump_scaler : three scaler+MAC pairs (4/2, 4/3, 16/17) on one stimulus
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_dump_scaler;

   typedef struct {
      string name;
      int    g;
      int    a;
      int    b;
      int    n;
      int    gap;
      int    expD;
      int    expS;
   } vec_t;

   typedef struct {
      int                 g;
      int                 cyc;
      logic signed [17:0] d;
   } ev_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               flush = 1'b0;
   logic               inValid = 1'b0;
   logic signed [17:0] aIn = '0;
   logic signed [17:0] bIn = '0;
   logic signed [17:0] dout [3];
   logic               dv [3];
   logic               sat [3];
   logic               accV [3];
   logic               clrV [3];

   int   cyc = 0;
   int   nVec = 0;
   int   nErr = 0;
   ev_t  evq[$];
   vec_t vecs[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int SL = (g == 2) ? 16 : 4;
      localparam int SH = (g == 0) ? 2 : ((g == 1) ? 3 : 17);
      logic signed [17:0] mA, mB;
      logic signed [47:0] mP;

      mac_dump_scaler #(.SUM_LEN(SL), .SHIFT(SH), .OUT_WIDTH(18)) u_dut (
         .clk(clk), .reset(reset), .flush(flush),
         .aIn(aIn), .bIn(bIn), .inValid(inValid),
         .macA(mA), .macB(mB), .macAcc(accV[g]), .macAccClr(clrV[g]),
         .macP(mP), .dout(dout[g]), .doutValid(dv[g]), .satFlag(sat[g])
      );

      dsp48_mac u_mac (
         .clk(clk), .reset(reset), .a(mA), .b(mB),
         .acc(accV[g]), .accClr(clrV[g]), .p(mP)
      );
   end

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++)
         if (dv[g]) evq.push_back('{g: g, cyc: cyc, d: dout[g]});
   end

   task automatic chk(input string name, input longint act, input longint exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int a, input int b, input logic v, input logic f);
      aIn     = 18'(a);
      bIn     = 18'(b);
      inValid = v;
      flush   = f;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      inValid = 1'b0;
      flush   = 1'b0;
      reset   = 1'b1;
      #1;
      chk("reset dout", dout[0], 0);
      chk("reset doutValid", dv[0], 0);
      chk("reset satFlag", sat[2], 0);
      chk("reset macAccClr", clrV[0], 1);
      chk("reset macAcc", accV[0], 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic scan(input int g, output int n, output ev_t e0, output ev_t e1);
      n  = 0;
      e0 = '{g: 0, cyc: 0, d: '0};
      e1 = e0;
      foreach (evq[i]) begin
         if (evq[i].g == g) begin
            if (n == 0) e0 = evq[i];
            else if (n == 1) e1 = evq[i];
            n++;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  c0, n;
      ev_t e0, e1;
      do_reset();
      evq.delete();
      c0 = 0;
      for (int i = 0; i < v.n; i++) begin
         drive(v.a, v.b, 1'b1, 1'b0);
         c0 = cyc;
         if (i < v.n - 1) repeat (v.gap) drive(0, 0, 1'b0, 1'b0);
      end
      repeat (8) drive(0, 0, 1'b0, 1'b0);
      scan(v.g, n, e0, e1);
      chk({v.name, " strobes"}, n, 1);
      chk({v.name, " dout"}, e0.d, v.expD);
      chk({v.name, " latency"}, e0.cyc - c0, 4);
      chk({v.name, " satFlag"}, sat[v.g], v.expS);
   endtask

   task automatic abort_then_block(input string name, input logic useReset);
      int  c0, n;
      ev_t e0, e1;
      do_reset();
      evq.delete();
      drive(10, 10, 1'b1, 1'b0);
      drive(10, 10, 1'b1, 1'b0);
      if (useReset) begin
         reset = 1'b1;
         #1;
         chk({name, " accClr in reset"}, clrV[0], 1);
         @(posedge clk);
         #1;
         reset = 1'b0;
      end else begin
         drive(50, 50, 1'b1, 1'b1);
         chk({name, " accClr pulse"}, clrV[0], 1);
         chk({name, " macA zeroed"}, g_dut[0].mA, 0);
         drive(0, 0, 1'b0, 1'b0);
         chk({name, " accClr single"}, clrV[0], 0);
      end
      c0 = 0;
      for (int i = 0; i < 4; i++) begin
         drive(10, 10, 1'b1, 1'b0);
         c0 = cyc;
      end
      repeat (8) drive(0, 0, 1'b0, 1'b0);
      scan(0, n, e0, e1);
      chk({name, " strobes"}, n, 1);
      chk({name, " dout"}, e0.d, 100);
      chk({name, " latency"}, e0.cyc - c0, 4);
   endtask

   initial begin : main
      int  c1, n;
      ev_t e0, e1;

      // name, instance, a, b, pairs, gap, expected dout, expected satFlag
      vecs.push_back('{"contig", 0, 100, 3, 4, 0, 300, 0});
      vecs.push_back('{"gapped", 0, 100, 3, 4, 2, 300, 0});
`ifdef MAC_DUMP_ROUND_EN
      vecs.push_back('{"neg_half", 1, -5, 1, 4, 0, -2, 0});
      vecs.push_back('{"pos_half", 1, 5, 1, 4, 0, 3, 0});
`else
      vecs.push_back('{"neg_half", 1, -5, 1, 4, 0, -3, 0});
      vecs.push_back('{"pos_half", 1, 5, 1, 4, 0, 2, 0});
`endif
      vecs.push_back('{"neg_exact", 1, -4, 1, 4, 0, -2, 0});
      vecs.push_back('{"at_max", 0, 131071, 1, 4, 0, 131071, 0});
      vecs.push_back('{"at_min", 0, -131072, 1, 4, 0, -131072, 0});
      vecs.push_back('{"sat_neg", 2, -131072, 131071, 16, 0, -131072, 1});
      vecs.push_back('{"sat_pos", 2, -131072, -131072, 16, 0, 131071, 1});

      foreach (vecs[i]) run_vec(vecs[i]);

      repeat (5) drive(0, 0, 1'b0, 1'b0);
      chk("satFlag sticky", sat[2], 1);
      drive(0, 0, 1'b0, 1'b1);
      chk("satFlag flush clear", sat[2], 0);

      do_reset();
      evq.delete();
      for (int i = 0; i < 4; i++) drive(1, 1, 1'b1, 1'b0);
      c1 = cyc;
      for (int i = 0; i < 4; i++) drive(2, 2, 1'b1, 1'b0);
      repeat (8) drive(0, 0, 1'b0, 1'b0);
      scan(0, n, e0, e1);
      chk("b2b strobes", n, 2);
      chk("b2b dout0", e0.d, 1);
      chk("b2b dout1", e1.d, 4);
      chk("b2b latency", e0.cyc - c1, 4);
      chk("b2b spacing", e1.cyc - e0.cyc, 4);

      abort_then_block("flush", 1'b0);
      abort_then_block("reset", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

`default_nettype wire
